id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the 32-bit LoongArch core: captures the decoded instruction from ID and presents source/destination register indices and payload to EX, where the forwarding unit consumes `ex_rs`, `ex_rd` and the stage's write flags. It owns load-use hazard detection, inserting exactly one bubble so a load's result can be forwarded from WB. It also handles downstream back-pressure and branch flush.

## Interface
- `PAY_W`, 128: width of the opaque decoded payload (PC, operand values, control word).
- `CNT_W`, 32: width of the bubble counter (only with `ID_EX_PERF_CNT_EN`).
- `clk` in 1: the single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_ready` out 1: this stage accepts the ID instruction this cycle.
- `id_rs` in `REG_LOG*3`: {rs2, rs1, rs0} indices.
- `id_rs_used` in 3: per-operand "index is a real read" mask; bit i ↔ rs_i.
- `id_rd` in `REG_LOG`: destination index.
- `id_reg_write` in 1: instruction writes `id_rd`.
- `id_mem_read` in 1: instruction is a load.
- `id_payload` in `PAY_W`: passed through unchanged.
- `ex_ready` in 1: EX can accept a new instruction (low during multi-cycle ops).
- `flush` in 1: branch/jump redirect resolved in EX; kill ID and the entry being loaded.
- `ex_valid` out 1: register holds a valid instruction.
- `ex_rs` out `REG_LOG*3`, `ex_rd` out `REG_LOG`, `ex_reg_write` out 1, `ex_mem_read` out 1, `ex_payload` out `PAY_W`: registered copies.
- `bubble_cnt` out `CNT_W`: load-use bubbles inserted (only with `ID_EX_PERF_CNT_EN`).

## Operation
- Register update occurs only when `ex_ready`=1 or `flush`=1; otherwise all outputs hold (HOLD).
- Load-use hazard `lu` = `ex_valid & ex_mem_read & |ex_rd & id_valid & (any i: id_rs_used[i] & id_rs_i == ex_rd)`.
- Priority on an update edge: flush > lu > load.
  - flush: `ex_valid`←0, all index/flag fields←0; ID instruction discarded.
  - lu: bubble; `ex_valid`←0, fields←0; ID instruction held (not accepted).
  - load: `ex_valid`←`id_valid`; fields←ID inputs; any rs_i with `id_rs_used[i]`=0 is stored as 0.
- `id_ready` = `flush | (ex_ready & ~lu)`. While flush is high the ID instruction is consumed and dropped.
- Bubble and invalid entries always carry `ex_reg_write`=0, `ex_mem_read`=0, `ex_rd`=0 and `ex_rs`=0, so the forwarding unit never matches them.
- `lu` is evaluated against the current register contents. After one bubble, the load is in MEM, so `lu` deasserts and the consumer enters EX when the load reaches WB.
- States, implicit in (`ex_valid`, update condition):
  - RUN: loading.
  - HOLD: `ex_ready`=0.
  - BUBBLE: lu edge.
  - BUBBLE→RUN is guaranteed on the next update edge unless a new hazard arises.

## Timing
- Latency: ID inputs appear on outputs 1 cycle after an accepting edge.
- `id_ready` is combinational from `ex_*` registers, `id_*`, `ex_ready` and `flush`. There is no combinational path from `id_payload` to outputs.
- Reset (async assert, sync-safe release): `ex_valid`=0, all fields=0, `ex_payload`=0, `bubble_cnt`=0.
- Reset asserted mid-hold or mid-bubble clears everything immediately. The first post-reset edge with `id_valid`=1 and `ex_ready`=1 loads normally.
- Simultaneous lu and `ex_ready`=0: hold; no bubble is counted. The bubble is inserted on the first edge where `ex_ready`=1.
- Simultaneous flush and lu: flush wins; the counter does not increment.

## Configuration
- `ID_EX_PERF_CNT_EN` defined: `bubble_cnt` port exists.
  - Increments by 1 on each lu bubble edge.
  - Wraps modulo 2^`CNT_W`.
  - Unaffected by flush or hold.
- Not defined: no port and no counter logic; all other behaviour is identical.

## Structure
- `REG_LOG` comes from the existing shared parameter header.
- Add `ID_EX_PERF_CNT_EN` and the bubble-field-clear constants there.
- One sub-module `load_use_detect`, purely combinational: inputs are `ex_valid`, `ex_mem_read`, `ex_rd`, `id_valid`, `id_rs`, `id_rs_used`; output is `lu`.
- The top module holds the registers, priority mux and counter.

## Test plan
- Reset with `rstn`=0 mid-stream → all outputs 0 within the same cycle. Release, then `id_valid`=1, `id_rs`={0,2,1}, `id_rd`=3, `ex_ready`=1 → next cycle `ex_valid`=1, `ex_rd`=3.
- EX holds load with `ex_rd`=5; ID has rs1=5, `id_rs_used`=3'b010 → `id_ready`=0, one bubble (`ex_valid`=0, `ex_rs`=0), then the consumer loads; `bubble_cnt` 0→1.
- Same as above but `id_rs_used`=3'b000 with rs1=5 → no bubble, `ex_rs`=0 after load.
- Load with `ex_rd`=0 and ID rs0=0 used → no bubble.
- `ex_ready`=0 for 3 cycles with lu present → outputs frozen; bubble on the 4th edge only; `bubble_cnt` +1.
- `flush`=1 coincident with lu and `id_valid`=1 → `id_ready`=1, next `ex_valid`=0, `bubble_cnt` unchanged.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared core parameters and ID/EX register field types
//
// Optional feature macro: ID_EX_PERF_CNT_EN (enables the load-use bubble counter
// in id_ex_stage). Define it on the tool command line; this package only holds
// the constants the stage uses for cleared bubble/invalid entries.
package id_ex_stage_pkg;

  // Log2 of the architectural register file size (32 GPRs).
  localparam int REG_LOG = 5;
  localparam int RS_W    = REG_LOG * 3;

  // Control half of the ID/EX register; everything the forwarding unit looks at.
  typedef struct packed {
    logic               valid;
    logic [RS_W-1:0]    rs;
    logic [REG_LOG-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } ex_ctrl_t;

  // Bubble and invalid entries must never match in the forwarding unit, so
  // every index and flag is cleared, not just the valid bit.
  localparam logic [RS_W-1:0]    EX_RS_CLR   = '0;
  localparam logic [REG_LOG-1:0] EX_RD_CLR   = '0;
  localparam ex_ctrl_t           EX_CTRL_CLR = '{valid: 1'b0, rs: EX_RS_CLR,
                                                 rd: EX_RD_CLR, reg_write: 1'b0,
                                                 mem_read: 1'b0};

  // Zero every source index whose operand is not actually read.
  function automatic logic [RS_W-1:0] mask_rs(input logic [RS_W-1:0] rs,
                                              input logic [2:0]      used);
    logic [RS_W-1:0] res;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      res[i*REG_LOG +: REG_LOG] = used[i] ? rs[i*REG_LOG +: REG_LOG] : '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard detector
//
// Ports:
//   ex_valid, ex_mem_read, ex_rd : instruction currently held in ID/EX
//   id_valid, id_rs, id_rs_used  : instruction waiting in ID
//   lu                           : ID consumes the result of the load in EX
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [REG_LOG-1:0] ex_rd,
  input  logic               id_valid,
  input  logic [RS_W-1:0]    id_rs,
  input  logic [2:0]         id_rs_used,
  output logic               lu
);

  logic [2:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < 3; i++) begin
      match[i] = id_rs_used[i] && (id_rs[i*REG_LOG +: REG_LOG] == ex_rd);
    end
  end

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = ex_valid & ex_mem_read & (|ex_rd) & id_valid & (|match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, hold and flush
//
// Optional feature macro: ID_EX_PERF_CNT_EN adds the bubble_cnt port/counter.
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   id_valid/id_ready               : handshake with ID
//   id_rs, id_rs_used, id_rd,
//   id_reg_write, id_mem_read,
//   id_payload                      : decoded instruction from ID
//   ex_ready                        : EX can take a new instruction
//   flush                           : redirect from EX, kills ID and the entry loaded
//   ex_valid, ex_rs, ex_rd,
//   ex_reg_write, ex_mem_read,
//   ex_payload                      : registered instruction presented to EX
//   bubble_cnt                      : count of load-use bubbles (optional)
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int PAY_W = 128
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [RS_W-1:0]    id_rs,
  input  logic [2:0]         id_rs_used,
  input  logic [REG_LOG-1:0] id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic [PAY_W-1:0]   id_payload,
  input  logic               ex_ready,
  input  logic               flush,
  output logic               ex_valid,
  output logic [RS_W-1:0]    ex_rs,
  output logic [REG_LOG-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic [PAY_W-1:0]   ex_payload
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  ex_ctrl_t         ctrl_d, ctrl_q;
  logic [PAY_W-1:0] pay_d, pay_q;
  logic             lu;
  logic             bubble;

  load_use_detect u_lu (
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (ctrl_q.rd),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .lu          (lu)
  );

  assign id_ready = flush | (ex_ready & ~lu);
  // A bubble is only counted when it is actually inserted: flush overrides it
  // and a held register inserts nothing.
  assign bubble   = ~flush & ex_ready & lu;

  always_comb begin
    ctrl_d = ctrl_q;
    pay_d  = pay_q;
    if (flush || bubble) begin
      ctrl_d = EX_CTRL_CLR;
    end else if (ex_ready) begin
      if (id_valid) begin
        ctrl_d.valid     = 1'b1;
        ctrl_d.rs        = mask_rs(id_rs, id_rs_used);
        ctrl_d.rd        = id_rd;
        ctrl_d.reg_write = id_reg_write;
        ctrl_d.mem_read  = id_mem_read;
        pay_d            = id_payload;
      end else begin
        ctrl_d = EX_CTRL_CLR;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q <= EX_CTRL_CLR;
      pay_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pay_q  <= pay_d;
    end
  end

  assign ex_valid     = ctrl_q.valid;
  assign ex_rs        = ctrl_q.rs;
  assign ex_rd        = ctrl_q.rd;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_payload   = pay_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (bubble) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int PAY_W = 128;
  localparam int CNT_W = 32;

  typedef struct {
    logic               valid;
    logic [RS_W-1:0]    rs;
    logic [REG_LOG-1:0] rd;
    logic               rw;
    logic               mr;
    logic [CNT_W-1:0]   cnt;
    logic               chk_pay;
    logic [PAY_W-1:0]   pay;
  } exp_t;

  logic               clk = 1'b0;
  logic               rstn;
  logic               id_valid;
  logic               id_ready;
  logic [RS_W-1:0]    id_rs;
  logic [2:0]         id_rs_used;
  logic [REG_LOG-1:0] id_rd;
  logic               id_reg_write;
  logic               id_mem_read;
  logic [PAY_W-1:0]   id_payload;
  logic               ex_ready;
  logic               flush;
  logic               ex_valid;
  logic [RS_W-1:0]    ex_rs;
  logic [REG_LOG-1:0] ex_rd;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic [PAY_W-1:0]   ex_payload;
  logic [CNT_W-1:0]   bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t st_q[$];
  logic rdy_q[$];

  always #5 clk = ~clk;

  id_ex_stage #(
    .PAY_W (PAY_W)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_payload   (id_payload),
    .ex_ready     (ex_ready),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_rs        (ex_rs),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_payload   (ex_payload)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt   (bubble_cnt)
`endif
  );

`ifndef ID_EX_PERF_CNT_EN
  assign bubble_cnt = '0;
`endif

  function automatic logic [RS_W-1:0] rs3(input int r2, input int r1, input int r0);
    return {REG_LOG'(r2), REG_LOG'(r1), REG_LOG'(r0)};
  endfunction

  function automatic logic [PAY_W-1:0] pay_of(input int idx);
    return {32'hC0DE_0000, 64'h0, 32'hA500_0000 + 32'(idx)};
  endfunction

  function automatic exp_t mk(input logic v, input logic [RS_W-1:0] rs,
                              input int rd, input logic rw, input logic mr,
                              input int cnt, input int pay_idx);
    exp_t e;
    e.valid   = v;
    e.rs      = rs;
    e.rd      = REG_LOG'(rd);
    e.rw      = rw;
    e.mr      = mr;
    e.cnt     = CNT_W'(cnt);
    e.chk_pay = (pay_idx >= 0);
    e.pay     = pay_of(pay_idx);
    return e;
  endfunction

  task automatic chk(input string name, input logic [PAY_W-1:0] act,
                     input logic [PAY_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of ID/EX inputs and queue what the DUT must show.
  task automatic cyc(input int idx, input logic v, input logic [RS_W-1:0] rs,
                     input logic [2:0] used, input int rd, input logic rw,
                     input logic mr, input logic er, input logic fl,
                     input logic e_rdy, input exp_t e);
    @(negedge clk);
    id_valid     = v;
    id_rs        = rs;
    id_rs_used   = used;
    id_rd        = REG_LOG'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    id_payload   = pay_of(idx);
    ex_ready     = er;
    flush        = fl;
    #1;
    rdy_q.push_back(e_rdy);
    st_q.push_back(e);
  endtask

  // Combinational id_ready, sampled mid low phase after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rdy_q.size() > 0) begin
        logic er;
        er = rdy_q.pop_front();
        chk("id_ready", PAY_W'(id_ready), PAY_W'(er));
      end
    end
  end

  // Registered outputs, sampled just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        exp_t e;
        e = st_q.pop_front();
        chk("ex_valid", PAY_W'(ex_valid), PAY_W'(e.valid));
        chk("ex_rs", PAY_W'(ex_rs), PAY_W'(e.rs));
        chk("ex_rd", PAY_W'(ex_rd), PAY_W'(e.rd));
        chk("ex_reg_write", PAY_W'(ex_reg_write), PAY_W'(e.rw));
        chk("ex_mem_read", PAY_W'(ex_mem_read), PAY_W'(e.mr));
        if (e.chk_pay) chk("ex_payload", ex_payload, e.pay);
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", PAY_W'(bubble_cnt), PAY_W'(e.cnt));
`endif
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_valid"}, PAY_W'(ex_valid), '0);
    chk({tag, "_ex_rs"}, PAY_W'(ex_rs), '0);
    chk({tag, "_ex_rd"}, PAY_W'(ex_rd), '0);
    chk({tag, "_ex_reg_write"}, PAY_W'(ex_reg_write), '0);
    chk({tag, "_ex_mem_read"}, PAY_W'(ex_mem_read), '0);
    chk({tag, "_ex_payload"}, ex_payload, '0);
    chk({tag, "_bubble_cnt"}, PAY_W'(bubble_cnt), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_payload = '0;
    ex_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    // plain load, then a load producing r5
    cyc(1, 1, rs3(0,2,1), 3'b111, 3, 1, 0, 1, 0, 1, mk(1, rs3(0,2,1), 3, 1, 0, 0, 1));
    cyc(2, 1, rs3(0,0,0), 3'b000, 5, 1, 1, 1, 0, 1, mk(1, '0, 5, 1, 1, 0, 2));
    // consumer of r5 via rs1: one bubble, then it loads with unused rs0 zeroed
    cyc(3, 1, rs3(0,5,7), 3'b010, 6, 1, 0, 1, 0, 0, mk(0, '0, 0, 0, 0, 1, -1));
    cyc(4, 1, rs3(0,5,7), 3'b010, 6, 1, 0, 1, 0, 1, mk(1, rs3(0,5,0), 6, 1, 0, 1, 4));
    // same index but operand not read: no bubble
    cyc(5, 1, rs3(0,0,0), 3'b000, 5, 1, 1, 1, 0, 1, mk(1, '0, 5, 1, 1, 1, 5));
    cyc(6, 1, rs3(0,5,0), 3'b000, 7, 1, 0, 1, 0, 1, mk(1, '0, 7, 1, 0, 1, 6));
    // load to r0 never stalls a reader of r0
    cyc(7, 1, rs3(0,0,0), 3'b000, 0, 0, 1, 1, 0, 1, mk(1, '0, 0, 0, 1, 1, 7));
    cyc(8, 1, rs3(0,0,0), 3'b001, 8, 1, 0, 1, 0, 1, mk(1, '0, 8, 1, 0, 1, 8));
    // hazard during 3 hold cycles: frozen, bubble only on the 4th edge
    cyc(9, 1, rs3(0,0,0), 3'b000, 9, 1, 1, 1, 0, 1, mk(1, '0, 9, 1, 1, 1, 9));
    for (int k = 10; k <= 12; k++) begin
      cyc(k, 1, rs3(9,0,0), 3'b100, 10, 1, 0, 0, 0, 0, mk(1, '0, 9, 1, 1, 1, 9));
    end
    cyc(13, 1, rs3(9,0,0), 3'b100, 10, 1, 0, 1, 0, 0, mk(0, '0, 0, 0, 0, 2, -1));
    cyc(14, 1, rs3(9,0,0), 3'b100, 10, 1, 0, 1, 0, 1, mk(1, rs3(9,0,0), 10, 1, 0, 2, 14));
    // flush coincident with a hazard: consumed, no bubble counted
    cyc(15, 1, rs3(0,0,0), 3'b000, 11, 1, 1, 1, 0, 1, mk(1, '0, 11, 1, 1, 2, 15));
    cyc(16, 1, rs3(0,0,11), 3'b001, 12, 1, 0, 1, 1, 1, mk(0, '0, 0, 0, 0, 2, -1));
    cyc(17, 0, rs3(0,0,11), 3'b001, 0, 0, 0, 1, 0, 1, mk(0, '0, 0, 0, 0, 2, -1));
    // hold with a pending hazard, then asynchronous reset mid-hold
    cyc(18, 1, rs3(0,0,0), 3'b000, 12, 1, 1, 1, 0, 1, mk(1, '0, 12, 1, 1, 2, 18));
    cyc(19, 1, rs3(0,0,12), 3'b001, 13, 1, 0, 0, 0, 0, mk(1, '0, 12, 1, 1, 2, 18));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cyc(20, 1, rs3(0,2,1), 3'b111, 3, 1, 0, 1, 0, 1, mk(1, rs3(0,2,1), 3, 1, 0, 0, 20));
    cyc(21, 0, rs3(0,0,0), 3'b000, 0, 0, 0, 1, 0, 1, mk(0, '0, 0, 0, 0, 0, -1));

    repeat (3) @(negedge clk);
    chk("scoreboard_state_drained", PAY_W'(st_q.size()), '0);
    chk("scoreboard_ready_drained", PAY_W'(rdy_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
